// File: rtl/gradient_controller.sv
// gradient_controller: 3-row Sobel window producing 14 gradient magnitudes/directions,
// two columns per cycle, committed together after 7 compute cycles.
module gradient_controller (
    input  logic             clk,
    input  logic             rst,
    input  logic             blur_valid,
    input  logic             col_start,
    input  logic [15:0][7:0] blur_in,
    output logic             busy,
    output logic [13:0][7:0] grad_out,
    output logic [13:0][1:0] grad_dir,
    output logic             grad_final,
    output logic             overrun
);
    typedef enum logic {IDLE, COMPUTE} state_t;
    state_t state;
    logic [2:0] pair;
    logic [2:0][15:0][7:0] win;
    logic [13:0][7:0] stage_mag, nxt_mag;
    logic [13:0][1:0] stage_dir, nxt_dir;
    logic [1:0][2:0][2:0][7:0] taps;

    function automatic logic [9:0] sobel(input logic [2:0][2:0][7:0] p);
        logic [10:0] gx, gy, ax, ay;
        logic [1:0] dir;
        gx = 11'(p[0][2]) + 11'({p[1][2], 1'b0}) + 11'(p[2][2])
           - 11'(p[0][0]) - 11'({p[1][0], 1'b0}) - 11'(p[2][0]);
        gy = 11'(p[2][0]) + 11'({p[2][1], 1'b0}) + 11'(p[2][2])
           - 11'(p[0][0]) - 11'({p[0][1], 1'b0}) - 11'(p[0][2]);
        ax = gx[10] ? -gx : gx;
        ay = gy[10] ? -gy : gy;
        dir = ({ay, 1'b0} <= {1'b0, ax}) ? 2'd0 :
              ({ax, 1'b0} <= {1'b0, ay}) ? 2'd2 :
              (gx[10] == gy[10])         ? 2'd1 : 2'd3;
        return {dir, 8'((ax + ay) >> 3)};
    endfunction

    always_comb begin
        nxt_mag = stage_mag;
        nxt_dir = stage_dir;
        taps = '0;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 3; r++)
                for (int j = 0; j < 3; j++)
                    taps[k][r][j] = win[r][4'(2 * int'(pair) + k + j)];
            {nxt_dir[4'(2 * int'(pair) + k)], nxt_mag[4'(2 * int'(pair) + k)]} = sobel(taps[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pair       <= '0;
            win        <= '0;
            stage_mag  <= '0;
            stage_dir  <= '0;
            grad_out   <= '0;
            grad_dir   <= '0;
            grad_final <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else if (state == IDLE) begin
            grad_final <= 1'b0;
            if (blur_valid) begin
                win   <= col_start ? {3{blur_in}} : {blur_in, win[2], win[1]};
                state <= COMPUTE;
                busy  <= 1'b1;
                pair  <= '0;
            end
        end else begin
            overrun   <= overrun | blur_valid;
            stage_mag <= nxt_mag;
            stage_dir <= nxt_dir;
            pair      <= pair + 3'd1;
            if (pair == 3'd6) begin
                state      <= IDLE;
                busy       <= 1'b0;
                grad_final <= 1'b1;
                grad_out   <= nxt_mag;
                grad_dir   <= nxt_dir;
            end
        end
    end
endmodule

// File: tb/tb_gradient_controller.sv
// tb_gradient_controller: directed and random strips checked against an integer Sobel model.
module tb_gradient_controller;
    logic             tb_clk = 1'b0;
    logic             rst, blur_valid, col_start;
    logic [15:0][7:0] blur_in;
    logic             busy, grad_final, overrun;
    logic [13:0][7:0] grad_out;
    logic [13:0][1:0] grad_dir;

    gradient_controller dut (
        .clk(tb_clk), .rst(rst), .blur_valid(blur_valid), .col_start(col_start),
        .blur_in(blur_in), .busy(busy), .grad_out(grad_out), .grad_dir(grad_dir),
        .grad_final(grad_final), .overrun(overrun)
    );

    always #5 tb_clk = ~tb_clk;

    int n_checks = 0;
    int n_fail = 0;
    int m_rows[3][16];
    int e_mag[14];
    int e_dir[14];
    bit e_ov;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0][7:0] fill(input int v);
        logic [15:0][7:0] r;
        for (int i = 0; i < 16; i++) r[i] = 8'(v);
        return r;
    endfunction

    function automatic logic [15:0][7:0] rnd_row();
        logic [15:0][7:0] r;
        for (int i = 0; i < 16; i++)
            r[i] = ($urandom_range(0, 3) == 0) ? 8'(255 * $urandom_range(0, 1)) : 8'($urandom);
        return r;
    endfunction

    task automatic model_load(input logic [15:0][7:0] d, input bit cs);
        for (int i = 0; i < 16; i++) begin
            m_rows[0][i] = cs ? int'(d[i]) : m_rows[1][i];
            m_rows[1][i] = cs ? int'(d[i]) : m_rows[2][i];
            m_rows[2][i] = int'(d[i]);
        end
    endtask

    task automatic model_eval();
        int p[3][3];
        int gx, gy, ax, ay;
        for (int c = 0; c < 14; c++) begin
            for (int r = 0; r < 3; r++)
                for (int j = 0; j < 3; j++) p[r][j] = m_rows[r][c + j];
            gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
            gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
            ax = gx < 0 ? -gx : gx;
            ay = gy < 0 ? -gy : gy;
            e_mag[c] = (ax + ay) / 8;
            if (2 * ay <= ax) e_dir[c] = 0;
            else if (2 * ax <= ay) e_dir[c] = 2;
            else if ((gx >= 0) == (gy >= 0)) e_dir[c] = 1;
            else e_dir[c] = 3;
        end
    endtask

    task automatic check_outs(input string tag);
        for (int c = 0; c < 14; c++) begin
            chk($sformatf("%s mag[%0d]", tag, c), 32'(grad_out[c]), 32'(e_mag[c]));
            chk($sformatf("%s dir[%0d]", tag, c), 32'(grad_dir[c]), 32'(e_dir[c]));
        end
        chk({tag, " overrun"}, 32'(overrun), 32'(e_ov));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(negedge tb_clk);
        rst = 1'b0;
        blur_valid = 1'b0;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 16; i++) m_rows[r][i] = 0;
        for (int c = 0; c < 14; c++) begin
            e_mag[c] = 0;
            e_dir[c] = 0;
        end
        e_ov = 1'b0;
        check_outs(tag);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " grad_final"}, 32'(grad_final), 0);
    endtask

    // Called at a negedge; returns at the negedge where grad_final is high, so a
    // following call strobes blur_valid into edge k+8.
    task automatic run(input logic [15:0][7:0] d, input bit cs, input int ov_at, input string tag);
        int cyc, busy_n;
        bit seen;
        blur_in = d;
        col_start = cs;
        blur_valid = 1'b1;
        @(negedge tb_clk);
        blur_valid = 1'b0;
        model_load(d, cs);
        cyc = 0;
        busy_n = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            cyc++;
            if (busy) busy_n++;
            if (grad_final) seen = 1'b1;
            else begin
                if (ov_at != 0 && cyc == ov_at) begin
                    blur_in = rnd_row();
                    col_start = 1'($urandom);
                    blur_valid = 1'b1;
                    e_ov = 1'b1;
                end
                @(negedge tb_clk);
                blur_valid = 1'b0;
            end
        end
        chk({tag, " latency"}, 32'(cyc), 8);
        chk({tag, " busy cycles"}, 32'(busy_n), 7);
        model_eval();
        check_outs(tag);
    endtask

    task automatic idle_check(input string tag);
        @(negedge tb_clk);
        chk({tag, " single grad_final"}, 32'(grad_final), 0);
        chk({tag, " idle busy"}, 32'(busy), 0);
    endtask

    initial begin
        int pulses;
        logic [15:0][7:0] v;
        rst = 1'b1;
        blur_valid = 1'b0;
        col_start = 1'b0;
        blur_in = '0;
        @(negedge tb_clk);
        do_reset("reset");

        run(fill(100), 1'b1, 0, "flat");
        idle_check("flat");

        for (int i = 0; i < 16; i++) v[i] = i < 8 ? 8'd0 : 8'd255;
        run(v, 1'b1, 0, "vstep");
        chk("vstep anchor mag6", 32'(grad_out[6]), 127);
        chk("vstep anchor mag7", 32'(grad_out[7]), 127);
        idle_check("vstep");

        run(fill(0), 1'b1, 0, "hstep0");
        run(fill(255), 1'b0, 0, "hstep1");
        chk("hstep1 anchor mag", 32'(grad_out[0]), 127);
        chk("hstep1 anchor dir", 32'(grad_dir[0]), 2);
        run(fill(255), 1'b0, 0, "hstep2");
        run(fill(255), 1'b0, 0, "hstep3");
        chk("hstep3 anchor mag", 32'(grad_out[13]), 0);
        idle_check("hstep");

        for (int n = 0; n < 8; n++) begin
            run(rnd_row(), n == 0 ? 1'b1 : 1'($urandom_range(0, 3) == 0), 0, $sformatf("rnd%0d", n));
            repeat ($urandom_range(0, 2)) @(negedge tb_clk);
        end
        idle_check("rnd");

        run(rnd_row(), 1'b0, 3, "overrun");
        idle_check("overrun");
        run(rnd_row(), 1'b0, 0, "post-overrun");
        idle_check("post-overrun");

        blur_in = rnd_row();
        col_start = 1'b1;
        blur_valid = 1'b1;
        @(negedge tb_clk);
        repeat (3) @(negedge tb_clk);
        blur_valid = 1'b1;
        do_reset("midreset");
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge tb_clk);
            if (grad_final) pulses++;
        end
        chk("midreset pulses", 32'(pulses), 0);
        chk("midreset busy", 32'(busy), 0);
        run(fill(100), 1'b1, 0, "flat-after-reset");

        for (int n = 0; n < 6; n++)
            run(rnd_row(), 1'($urandom_range(0, 1)), 0, $sformatf("b2b%0d", n));
        idle_check("b2b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
